// File: rtl/othello_move_engine.sv
// NxN Othello board store with an 8-direction move validator and a flip
// streamer. Scans one cell per cycle; in place mode it streams every cell
// change (placed disc first, then flips) over a valid/ready port.
module othello_move_engine #(
    parameter int BOARD_N = 8,
    parameter int CW      = $clog2(BOARD_N),
    parameter int FW      = $clog2(8*BOARD_N)
) (
    input  logic          clock,
    input  logic          resetn,
    input  logic          init,
    input  logic          start,
    input  logic          mode,
    input  logic [CW-1:0] x,
    input  logic [CW-1:0] y,
    input  logic [1:0]    side,
    output logic          busy,
    output logic          done,
    output logic          legal,
    output logic [7:0]    dir_valid,
    output logic [FW-1:0] flip_count,
    output logic          wr_valid,
    input  logic          wr_ready,
    output logic [CW-1:0] wr_x,
    output logic [CW-1:0] wr_y,
    output logic [1:0]    wr_side,
    input  logic [CW-1:0] rd_x,
    input  logic [CW-1:0] rd_y,
    output logic [1:0]    rd_q
);
    // One spare bit so a step off either edge is seen as >= BOARD_N.
    localparam int PW = CW + 1;
    typedef logic [PW-1:0] pos_t;
    typedef enum logic [2:0] {IDLE, SCAN, PLACE, FLIP, DONE} state_t;
    typedef struct packed {
        logic [CW-1:0] x;
        logic [CW-1:0] y;
        logic [1:0]    side;
        logic          mode;
    } req_t;

    logic [1:0] board [BOARD_N][BOARD_N];   // board[row][col]
    state_t        st, st_nxt;
    req_t          req;
    pos_t          cx, cy;
    logic [2:0]    dir;
    logic [FW-1:0] run;

    pos_t       nx, ny, tx, ty;
    logic       off, tgt_bad, step_opp, step_hit, flip_cont, hs;
    logic [1:0] ncell, tcell, opp;
    logic [7:0] dv_new;
    logic [3:0] nd_place, nd_flip;

    function automatic pos_t step_x(pos_t p, logic [2:0] d);
        case (d)
            3'd1, 3'd2, 3'd3: return p + pos_t'(1);
            3'd5, 3'd6, 3'd7: return p - pos_t'(1);
            default:          return p;
        endcase
    endfunction

    function automatic pos_t step_y(pos_t p, logic [2:0] d);
        case (d)
            3'd0, 3'd1, 3'd7: return p - pos_t'(1);
            3'd3, 3'd4, 3'd5: return p + pos_t'(1);
            default:          return p;
        endcase
    endfunction

    // Lowest set direction at or above 'from'; msb flags that one exists.
    function automatic logic [3:0] first_dir(logic [7:0] mask, int from);
        logic [3:0] r;
        r = 4'b0;
        for (int i = 7; i >= 0; i--)
            if (mask[i] && i >= from) r = {1'b1, 3'(i)};
        return r;
    endfunction

    function automatic logic [1:0] start_cell(int a, int b);
        int h;
        h = BOARD_N / 2;
        if ((a == h-1 && b == h-1) || (a == h && b == h)) return 2'b10;
        if ((a == h && b == h-1) || (a == h-1 && b == h)) return 2'b01;
        return 2'b00;
    endfunction

    // Neighbour of the walk cursor, target status and flip-walk look-ahead.
    always_comb begin
        tx        = {1'b0, req.x};
        ty        = {1'b0, req.y};
        nx        = step_x(cx, dir);
        ny        = step_y(cy, dir);
        off       = (nx >= pos_t'(BOARD_N)) || (ny >= pos_t'(BOARD_N));
        ncell     = off ? 2'b00 : board[ny[CW-1:0]][nx[CW-1:0]];
        tcell     = board[req.y][req.x];
        opp       = ~req.side;
        tgt_bad   = (tx >= pos_t'(BOARD_N)) || (ty >= pos_t'(BOARD_N)) ||
                    (tcell != 2'b00) || (req.side == 2'b00) || (req.side == 2'b11);
        step_opp  = !off && (ncell == opp);
        step_hit  = !off && (ncell == req.side) && (run != '0);
        dv_new    = dir_valid | (step_hit ? (8'b1 << dir) : 8'b0);
        flip_cont = (ncell == opp);
        nd_place  = first_dir(dir_valid, 0);
        nd_flip   = first_dir(dir_valid, int'(dir) + 1);
    end

    // State register.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) st <= IDLE;
        else         st <= st_nxt;
    end

    // Next state and handshake / status outputs.
    always_comb begin
        st_nxt   = st;
        busy     = 1'b0;
        done     = 1'b0;
        wr_valid = 1'b0;
        wr_x     = cx[CW-1:0];
        wr_y     = cy[CW-1:0];
        wr_side  = req.side;
        case (st)
            IDLE: begin
                if (init)       st_nxt = IDLE;
                else if (start) st_nxt = SCAN;
            end
            SCAN: begin
                busy = 1'b1;
                if (tgt_bad)
                    st_nxt = DONE;
                else if (!step_opp && dir == 3'd7)
                    st_nxt = (req.mode && |dv_new) ? PLACE : DONE;
            end
            PLACE: begin
                busy     = 1'b1;
                wr_valid = 1'b1;
                wr_x     = req.x;
                wr_y     = req.y;
                if (wr_ready) st_nxt = nd_place[3] ? FLIP : DONE;
            end
            FLIP: begin
                busy     = 1'b1;
                wr_valid = 1'b1;
                if (wr_ready && !flip_cont && !nd_flip[3]) st_nxt = DONE;
            end
            DONE: begin
                done = 1'b1;
                if (init)       st_nxt = IDLE;
                else if (start) st_nxt = SCAN;
                else            st_nxt = IDLE;
            end
            default: st_nxt = IDLE;
        endcase
    end

    assign hs = wr_valid && wr_ready;

    // Request latch, scan walker and result registers.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            req        <= '0;
            cx         <= '0;
            cy         <= '0;
            dir        <= '0;
            run        <= '0;
            legal      <= 1'b0;
            dir_valid  <= '0;
            flip_count <= '0;
        end else begin
            case (st)
                IDLE, DONE: begin
                    if (start && !init) begin
                        req        <= '{x: x, y: y, side: side, mode: mode};
                        cx         <= {1'b0, x};
                        cy         <= {1'b0, y};
                        dir        <= '0;
                        run        <= '0;
                        legal      <= 1'b0;
                        dir_valid  <= '0;
                        flip_count <= '0;
                    end
                end
                SCAN: begin
                    if (!tgt_bad) begin
                        if (step_opp) begin
                            run <= run + FW'(1);
                            cx  <= nx;
                            cy  <= ny;
                        end else begin
                            if (step_hit) begin
                                dir_valid[dir] <= 1'b1;
                                flip_count     <= flip_count + run;
                            end
                            if (dir == 3'd7) legal <= |dv_new;
                            run <= '0;
                            cx  <= tx;
                            cy  <= ty;
                            dir <= dir + 3'd1;
                        end
                    end
                end
                PLACE: begin
                    if (hs) begin
                        dir <= nd_place[2:0];
                        cx  <= step_x(tx, nd_place[2:0]);
                        cy  <= step_y(ty, nd_place[2:0]);
                    end
                end
                FLIP: begin
                    if (hs && flip_cont) begin
                        cx <= nx;
                        cy <= ny;
                    end else if (hs) begin
                        dir <= nd_flip[2:0];
                        cx  <= step_x(tx, nd_flip[2:0]);
                        cy  <= step_y(ty, nd_flip[2:0]);
                    end
                end
                default: ;
            endcase
        end
    end

    // Board store: start position on reset/init, one cell per accepted record.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            for (int b = 0; b < BOARD_N; b++)
                for (int a = 0; a < BOARD_N; a++)
                    board[b][a] <= start_cell(a, b);
        end else if (init && (st == IDLE || st == DONE)) begin
            for (int b = 0; b < BOARD_N; b++)
                for (int a = 0; a < BOARD_N; a++)
                    board[b][a] <= start_cell(a, b);
        end else if (hs) begin
            board[wr_y][wr_x] <= wr_side;
        end
    end

    // Combinational read port; coordinates beyond the board read as empty.
    always_comb begin
        rd_q = 2'b00;
        if ({1'b0, rd_x} < pos_t'(BOARD_N) && {1'b0, rd_y} < pos_t'(BOARD_N))
            rd_q = board[rd_y][rd_x];
    end
endmodule

// File: tb/tb_othello_move_engine.sv
// Self-checking bench: a direction-walking board model predicts legality,
// flip counts, the ordered cell-change stream and the board contents.
module tb_othello_move_engine;
    localparam int N   = 8;
    localparam int CW  = $clog2(N);
    localparam int FW  = $clog2(8*N);
    localparam int N6  = 6;
    localparam int CW6 = $clog2(N6);
    localparam int FW6 = $clog2(8*N6);

    logic          clock = 1'b0, resetn = 1'b0, init = 1'b0, start = 1'b0, mode = 1'b0;
    logic [CW-1:0] x = '0, y = '0, rd_x = '0, rd_y = '0;
    logic [1:0]    side = 2'b00;
    logic          wr_ready = 1'b1;
    logic          busy, done, legal, wr_valid;
    logic [7:0]    dir_valid;
    logic [FW-1:0] flip_count;
    logic [CW-1:0] wr_x, wr_y;
    logic [1:0]    wr_side, rd_q;

    logic [CW6-1:0] rd_x6 = '0, rd_y6 = '0;
    logic           busy6, done6, legal6, wr_valid6;
    logic [7:0]     dir_valid6;
    logic [FW6-1:0] flip_count6;
    logic [CW6-1:0] wr_x6, wr_y6;
    logic [1:0]     wr_side6, rd_q6;

    othello_move_engine #(.BOARD_N(N)) dut (
        .clock(clock), .resetn(resetn), .init(init), .start(start), .mode(mode),
        .x(x), .y(y), .side(side), .busy(busy), .done(done), .legal(legal),
        .dir_valid(dir_valid), .flip_count(flip_count), .wr_valid(wr_valid),
        .wr_ready(wr_ready), .wr_x(wr_x), .wr_y(wr_y), .wr_side(wr_side),
        .rd_x(rd_x), .rd_y(rd_y), .rd_q(rd_q));

    othello_move_engine #(.BOARD_N(N6)) dut6 (
        .clock(clock), .resetn(resetn), .init(1'b0), .start(1'b0), .mode(1'b0),
        .x('0), .y('0), .side(2'b00), .busy(busy6), .done(done6), .legal(legal6),
        .dir_valid(dir_valid6), .flip_count(flip_count6), .wr_valid(wr_valid6),
        .wr_ready(1'b1), .wr_x(wr_x6), .wr_y(wr_y6), .wr_side(wr_side6),
        .rd_x(rd_x6), .rd_y(rd_y6), .rd_q(rd_q6));

    initial forever #5 clock = ~clock;

    int checks = 0, errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int mb [N][N];    // mb[row][col], 0 empty 1 black 2 white
    int DX [8] = '{0, 1, 1, 1, 0, -1, -1, -1};
    int DY [8] = '{-1, -1, 0, 1, 1, 1, 0, -1};
    typedef struct {int x; int y; int s;} rec_t;
    rec_t exp_q [$];

    function automatic bit inb(int a, int b);
        return a >= 0 && a < N && b >= 0 && b < N;
    endfunction

    function automatic void model_reset();
        for (int b = 0; b < N; b++)
            for (int a = 0; a < N; a++) mb[b][a] = 0;
        mb[N/2-1][N/2-1] = 2; mb[N/2][N/2] = 2;
        mb[N/2-1][N/2]   = 1; mb[N/2][N/2-1] = 1;
    endfunction

    function automatic logic [7:0] model_scan(input int px, input int py, input int s, output int fc);
        logic [7:0] dv;
        int run, a, b;
        dv = '0; fc = 0;
        if (!(s == 1 || s == 2) || !inb(px, py)) return dv;
        if (mb[py][px] != 0) return dv;
        for (int d = 0; d < 8; d++) begin
            run = 0; a = px + DX[d]; b = py + DY[d];
            while (inb(a, b) && mb[b][a] == 3 - s) begin
                run++; a += DX[d]; b += DY[d];
            end
            if (inb(a, b) && mb[b][a] == s && run > 0) begin
                dv[d] = 1'b1; fc += run;
            end
        end
        return dv;
    endfunction

    task automatic model_place(input int px, input int py, input int s, input logic [7:0] dv);
        int a, b;
        exp_q.push_back('{px, py, s});
        mb[py][px] = s;
        for (int d = 0; d < 8; d++) if (dv[d]) begin
            a = px + DX[d]; b = py + DY[d];
            while (mb[b][a] == 3 - s) begin
                exp_q.push_back('{a, b, s});
                mb[b][a] = s; a += DX[d]; b += DY[d];
            end
        end
    endtask

    // ---------------- wr_ready driver ----------------
    int stall_mode = 2;   // 0 random, 1 five-low/one-high, 2 always ready
    initial begin
        int ph;
        ph = 0;
        forever begin
            @(posedge clock); #1;
            ph = (ph + 1) % 6;
            case (stall_mode)
                0:       wr_ready = ($urandom_range(0, 3) != 0);
                1:       wr_ready = (ph == 5);
                default: wr_ready = 1'b1;
            endcase
        end
    end

    // ---------------- per-cycle record compare ----------------
    int n_hs = 0;
    bit stalled = 0;
    logic [CW-1:0] sx, sy;
    logic [1:0]    ss;
    always @(negedge clock) begin : mon
        rec_t r;
        if (!resetn) stalled = 0;
        else if (wr_valid) begin
            if (stalled) begin
                chk("stall_wr_x", wr_x, sx);
                chk("stall_wr_y", wr_y, sy);
                chk("stall_wr_side", wr_side, ss);
            end
            if (wr_ready) begin
                if (exp_q.size() == 0) chk("wr_unexpected", 1, 0);
                else begin
                    r = exp_q.pop_front();
                    chk("wr_x", wr_x, r.x);
                    chk("wr_y", wr_y, r.y);
                    chk("wr_side", wr_side, r.s);
                end
                n_hs++;
                stalled = 0;
            end else begin
                stalled = 1; sx = wr_x; sy = wr_y; ss = wr_side;
            end
        end else begin
            if (stalled) chk("wr_valid_dropped", 0, 1);
            stalled = 0;
        end
    end

    // ---------------- stimulus helpers ----------------
    int last_cyc;

    task automatic sweep(input string nm);
        for (int b = 0; b < N; b++)
            for (int a = 0; a < N; a++) begin
                rd_x = CW'(a); rd_y = CW'(b); #1;
                chk(nm, rd_q, mb[b][a]);
            end
    endtask

    task automatic run_move(input int px, input int py, input int s, input int m,
                            input bit inject, input bit track);
        logic [7:0] edv;
        int efc, cyc, hs0;
        edv = model_scan(px, py, s, efc);
        if (m != 0 && edv != 0) model_place(px, py, s, edv);
        hs0 = n_hs;
        if (track) begin rd_x = 3; rd_y = 3; end
        @(posedge clock); #1;
        x = CW'(px); y = CW'(py); side = 2'(s); mode = m[0]; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        x = CW'($urandom); y = CW'($urandom); side = 2'($urandom); mode = 1'($urandom);
        #2;
        chk("busy_after_start", busy, 1);
        cyc = 1;
        while (!done && cyc < 400) begin
            if (track) chk("stall_rd33", rd_q, (n_hs - hs0 >= 2) ? 1 : 2);
            if (inject && cyc == 3) begin
                start = 1'b1; x = 0; y = 0; side = 2'b01; mode = 1'b1;
            end else start = 1'b0;
            @(posedge clock); #3;
            cyc++;
        end
        start = 1'b0;
        last_cyc = cyc;
        chk("done_seen", done, 1);
        chk("busy_at_done", busy, 0);
        chk("legal", legal, edv != 0);
        chk("dir_valid", dir_valid, edv);
        chk("flip_count", flip_count, efc);
        chk("records_left", exp_q.size(), 0);
        @(posedge clock); #3;
        chk("done_one_cycle", done, 0);
        chk("legal_held", legal, edv != 0);
        chk("flip_count_held", flip_count, efc);
    endtask

    task automatic pulse_init();
        @(posedge clock); #1; init = 1'b1;
        @(posedge clock); #1; init = 1'b0;
        #2;
        chk("busy_after_init", busy, 0);
        model_reset();
    endtask

    // ---------------- main sequence ----------------
    initial begin : main
        logic [7:0] dv;
        int fc, rx, ry, rs, rm, hs0, k;
        model_reset();
        resetn = 1'b0;
        repeat (3) @(posedge clock);
        #3;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_wr_valid", wr_valid, 0);
        chk("rst_legal", legal, 0);
        chk("rst_dir_valid", dir_valid, 0);
        chk("rst_flip_count", flip_count, 0);
        sweep("rst_board");
        for (int b = 0; b < N6; b++)
            for (int a = 0; a < N6; a++) begin
                rd_x6 = CW6'(a); rd_y6 = CW6'(b); #1;
                chk("rst_board6", rd_q6,
                    ((a == 2 && b == 2) || (a == 3 && b == 3)) ? 2 :
                    ((a == 3 && b == 2) || (a == 2 && b == 3)) ? 1 : 0);
            end
        @(negedge clock); resetn = 1'b1;

        // literal pins of the model for the opening move (2,3) black
        dv = model_scan(2, 3, 1, fc);
        chk("model_dv_23", dv, 8'b0000_0100);
        chk("model_fc_23", fc, 1);

        // place (2,3) with ready high; start while busy is injected
        stall_mode = 2;
        run_move(2, 3, 1, 1, 1'b1, 1'b0);
        chk("lit_dir_valid", dir_valid, 8'b0000_0100);
        chk("lit_flip_count", flip_count, 1);
        chk("lit_legal", legal, 1);
        rd_x = 3; rd_y = 3; #1;
        chk("lit_rd33", rd_q, 1);
        sweep("after_23");

        // check-only illegal corner move
        pulse_init();
        run_move(0, 0, 1, 0, 1'b0, 1'b0);
        chk("lit_00_legal", legal, 0);
        chk("lit_00_dv", dir_valid, 0);
        sweep("after_00");

        // occupied target
        run_move(3, 3, 1, 1, 1'b0, 1'b0);
        chk("occ_done_cycle", last_cyc, 2);

        // stalled place: 5 ready-low cycles per record
        stall_mode = 1;
        hs0 = n_hs;
        run_move(2, 3, 1, 1, 1'b0, 1'b1);
        chk("stall_record_count", n_hs - hs0, 2);
        sweep("after_stall");

        // init together with start: start must be dropped
        @(posedge clock); #1; init = 1'b1; start = 1'b1; x = 2; y = 3; side = 2'b01; mode = 1'b1;
        @(posedge clock); #1; init = 1'b0; start = 1'b0;
        #2;
        chk("init_start_busy", busy, 0);
        model_reset();
        sweep("after_init");

        // randomized games
        for (int i = 0; i < 160; i++) begin
            if (i % 40 == 39) pulse_init();
            stall_mode = ($urandom_range(0, 1) == 0) ? 0 : 2;
            rs = ($urandom_range(0, 9) == 0) ? (($urandom_range(0, 1) == 0) ? 0 : 3)
                                              : $urandom_range(1, 2);
            rm = (($urandom_range(0, 3)) != 0) ? 1 : 0;
            rx = $urandom_range(0, N-1); ry = $urandom_range(0, N-1);
            if ($urandom_range(0, 9) < 7 && (rs == 1 || rs == 2)) begin
                k = 0;
                while (k < 64 && model_scan(rx, ry, rs, fc) == 0) begin
                    rx = $urandom_range(0, N-1); ry = $urandom_range(0, N-1); k++;
                end
            end
            run_move(rx, ry, rs, rm,
                     (rs == 1 || rs == 2) && mb[ry][rx] == 0 && $urandom_range(0, 1) == 1,
                     1'b0);
            if (i % 10 == 9) sweep("rand_board");
        end
        sweep("rand_final");

        // reset asserted while flipping
        pulse_init();
        stall_mode = 1;
        dv = model_scan(2, 3, 1, fc);
        model_place(2, 3, 1, dv);
        hs0 = n_hs;
        @(posedge clock); #1; x = 2; y = 3; side = 2'b01; mode = 1'b1; start = 1'b1;
        @(posedge clock); #1; start = 1'b0;
        k = 0;
        while (!(wr_valid && n_hs - hs0 >= 1) && k < 100) begin
            @(posedge clock); #3; k++;
        end
        chk("reached_flip", wr_valid && (n_hs - hs0 >= 1), 1);
        resetn = 1'b0;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_wr_valid", wr_valid, 0);
        exp_q.delete();
        model_reset();
        sweep("abort_board");
        @(negedge clock); resetn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clock); #3;
            chk("abort_no_done", done, 0);
            chk("abort_idle", busy, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
